instr_decoder: RTL
==================

# instr_decoder

Registered RV32I instruction-class decoder with a valid/ready handshake and a 2-entry skid buffer. It sits between instruction fetch and the main controller. Each fetched 32-bit instruction is turned into the one-hot class flags (r_type, i_type, load, store, branch, jal, jalr, auipc, lui), the register and function fields, and an illegal flag. Full throughput is sustained under downstream backpressure.

## Interface
- ILEN, 32: instruction width; only 32 is supported.
- XLEN, 32: PC width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decoder accepts this cycle.
- in_instr  in  ILEN  raw instruction.
- in_pc  in  XLEN  instruction address.
- flush  in  1  discard all buffered entries.
- illegal_clear  in  1  clear the trap halt (used only with the trap feature).
- out_valid  out  1  decoded entry available.
- out_ready  in  1  controller consumes the entry.
- r_type, i_type, load, store, branch, jal, jalr, auipc, lui  out  1 each  class flags; at most one set.
- rd, rs1, rs2  out  5 each  instr[11:7], [19:15], [24:20].
- funct3  out  3  instr[14:12].
- funct7  out  7  instr[31:25].
- out_instr  out  ILEN  raw instruction passthrough.
- out_pc  out  XLEN  PC passthrough.
- illegal  out  1  entry failed decode; all class flags are 0.
- illegal_halt  out  1  sticky trap state.

## Operation
- Handshake rules:
  - A transfer occurs when valid and ready are both 1 in the same cycle.
  - The producer holds in_instr and in_pc stable while in_valid=1 and in_ready=0.
- Opcode (instr[6:0]) to class:
  - 0110011 → r_type; 0010011 → i_type; 0000011 → load; 0100011 → store; 1100011 → branch.
  - 1101111 → jal; 1100111 → jalr; 0010111 → auipc; 0110111 → lui.
- Illegal conditions:
  - any other opcode, including instr[1:0]≠11;
  - jalr with funct3≠000;
  - branch with funct3 of 010 or 011;
  - load with funct3 of 011, 110 or 111;
  - store with funct3≥011.
- Field outputs are raw slices and are valid for every class. Fields with no meaning for a class carry don't-care bits but are still driven.
- Buffer structure: a main register (drives the outputs) plus one skid register.
  - in_ready = !skid_valid && !illegal_halt. It is computed from registered state only.
  - Accept with the main register empty, or being drained this cycle → the entry loads into main; otherwise it loads into skid.
  - Main drained and skid full → skid moves to main in the same cycle.
  - Entries leave in strict FIFO order.
- flush: both registers are cleared at the next edge. An input transfer in the flush cycle is discarded. illegal_halt is unaffected.
- Reset: all outputs are 0, including in_ready while rst=1. in_ready is 1 in the first cycle after rst is released.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N has out_valid=1 after edge N.
- Throughput is 1 instruction per cycle while out_ready=1.
- out_ready=0 with one entry held → one more instruction is accepted into skid. in_ready then falls after that edge.
- Simultaneous consume and accept with skid full: skid moves to main, and no new accept is possible because in_ready=0.
- rst has priority over flush, and flush has priority over handshakes.
- All outputs come from registers; no combinational path runs from in_* to out_*.

## Configuration
- Macro: INSTR_DECODER_ILLEGAL_TRAP_EN.
- With the macro defined:
  - Accepting an illegal instruction sets illegal_halt at that edge, so in_ready=0 from the next cycle.
  - The illegal entry still drains downstream with illegal=1.
  - A single-cycle illegal_clear pulse clears illegal_halt.
  - If illegal_clear coincides with acceptance of a new illegal instruction, illegal_halt remains 1.
  - rst clears illegal_halt.
- Without the macro: illegal_halt is tied to 0, illegal_clear is ignored, and illegal entries pass through with illegal=1 only.

## Structure
- Shared package rv_decode_pkg holds:
  - the opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI);
  - a packed struct decoded_t (class flags, rd, rs1, rs2, funct3, funct7, instr, pc, illegal).
- One combinational sub-module, instr_classify (instr → decoded_t), is instantiated once on the input path. Both buffer registers store decoded_t.

## Test plan
- add x3,x1,x2 (0x002081B3), out_ready=1 → after 1 cycle: r_type=1, rd=3, rs1=1, rs2=2, funct3=0, funct7=0, illegal=0.
- lw x2,0(x1) (0x0000A103) then sw x2,4(x1) (0x0020A223), out_ready=0:
  - both instructions are accepted and in_ready=0 after the second edge;
  - raising out_ready yields load (rd=2), then store (rs2=2, rs1=1), in order on consecutive cycles.
- lui x1,0x12345 (0x123450B7) → lui=1, rd=1, other flags 0.
- jalr with funct3=001 (0x000010E7), trap enabled:
  - illegal=1, all flags 0, illegal_halt=1 and in_ready=0 from the next cycle;
  - an illegal_clear pulse restores in_ready=1 the following cycle.
- 0x00000000, trap disabled → illegal=1, illegal_halt=0, in_ready remains 1.
- Both entries full, then flush=1 with in_valid=1 → out_valid=0 after the edge, the presented instruction is not delivered, and in_ready=1.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode definitions: opcode constants and the decoded entry record.
package rv_decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef struct packed {
    logic        r_type;
    logic        i_type;
    logic        load;
    logic        store;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        auipc;
    logic        lui;
    logic        illegal;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] instr;
    logic [31:0] pc;
  } decoded_t;

endpackage

// File: rtl/instr_classify.sv
// Combinational RV32I class decode: raw instruction + PC into a decoded_t.
module instr_classify
  import rv_decode_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output decoded_t    dec_o
);

  logic [2:0] f3;
  logic [8:0] cls;
  logic       bad;

  assign f3 = instr_i[14:12];

  always_comb begin
    cls = 9'b0;
    bad = 1'b0;
    case (instr_i[6:0])
      OP_R:      cls = 9'b1_0000_0000;
      OP_I:      cls = 9'b0_1000_0000;
      OP_LOAD:   begin cls = 9'b0_0100_0000; bad = (f3 == 3'b011) || (f3[2:1] == 2'b11); end
      OP_STORE:  begin cls = 9'b0_0010_0000; bad = (f3 >= 3'b011); end
      OP_BRANCH: begin cls = 9'b0_0001_0000; bad = (f3[2:1] == 2'b01); end
      OP_JAL:    cls = 9'b0_0000_1000;
      OP_JALR:   begin cls = 9'b0_0000_0100; bad = (f3 != 3'b000); end
      OP_AUIPC:  cls = 9'b0_0000_0010;
      OP_LUI:    cls = 9'b0_0000_0001;
      default:   bad = 1'b1;
    endcase
  end

  // Illegal entries carry no class so the controller can never act on a bad opcode.
  always_comb begin
    dec_o = '0;
    {dec_o.r_type, dec_o.i_type, dec_o.load, dec_o.store, dec_o.branch,
     dec_o.jal, dec_o.jalr, dec_o.auipc, dec_o.lui} = bad ? 9'b0 : cls;
    dec_o.illegal = bad;
    dec_o.rd      = instr_i[11:7];
    dec_o.rs1     = instr_i[19:15];
    dec_o.rs2     = instr_i[24:20];
    dec_o.funct3  = f3;
    dec_o.funct7  = instr_i[31:25];
    dec_o.instr   = instr_i;
    dec_o.pc      = pc_i;
  end

endmodule

// File: rtl/instr_decoder.sv
// Registered RV32I decoder with valid/ready and a 2-entry (main + skid) buffer.
// Optional trap-on-illegal halt enabled by INSTR_DECODER_ILLEGAL_TRAP_EN.
module instr_decoder
  import rv_decode_pkg::*;
#(
  parameter int ILEN = 32,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            illegal_clear,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            r_type,
  output logic            i_type,
  output logic            load,
  output logic            store,
  output logic            branch,
  output logic            jal,
  output logic            jalr,
  output logic            auipc,
  output logic            lui,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            illegal,
  output logic            illegal_halt
);

  decoded_t in_dec, main_q, main_d, skid_q, skid_d;
  logic     main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, halt_q, halt_d;
  logic     acc;

  instr_classify u_classify (
    .instr_i (in_instr),
    .pc_i    (in_pc),
    .dec_o   (in_dec)
  );

  // Skid full already implies main full, so ready never waits on out_ready.
  assign in_ready = !rst && !skid_vld_q && !halt_q;
  assign acc      = in_valid && in_ready;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_d     = '0;
      main_vld_d = 1'b0;
      skid_d     = '0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || out_ready) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_d     = '0;
        skid_vld_d = 1'b0;
      end else begin
        main_d     = acc ? in_dec : '0;
        main_vld_d = acc;
      end
    end else if (acc) begin
      skid_d     = in_dec;
      skid_vld_d = 1'b1;
    end
  end

`ifdef INSTR_DECODER_ILLEGAL_TRAP_EN
  // A new illegal acceptance wins over a coincident clear.
  always_comb begin
    halt_d = halt_q;
    if (!flush) begin
      if (acc && in_dec.illegal) halt_d = 1'b1;
      else if (illegal_clear)    halt_d = 1'b0;
    end
  end
`else
  logic unused_clear;
  assign unused_clear = illegal_clear;
  assign halt_d       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      halt_q     <= halt_d;
    end
  end

  assign out_valid    = main_vld_q;
  assign r_type       = main_q.r_type;
  assign i_type       = main_q.i_type;
  assign load         = main_q.load;
  assign store        = main_q.store;
  assign branch       = main_q.branch;
  assign jal          = main_q.jal;
  assign jalr         = main_q.jalr;
  assign auipc        = main_q.auipc;
  assign lui          = main_q.lui;
  assign rd           = main_q.rd;
  assign rs1          = main_q.rs1;
  assign rs2          = main_q.rs2;
  assign funct3       = main_q.funct3;
  assign funct7       = main_q.funct7;
  assign out_instr    = main_q.instr;
  assign out_pc       = main_q.pc;
  assign illegal      = main_q.illegal;
  assign illegal_halt = halt_q;

endmodule
